cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single physical-memory port between the I-cache and D-cache of the pipelined LC-3b.
- Each cache issues whole-block (128-bit, 8-word) read or write-back requests.
- The arbiter grants one requester at a time, forwards its command to memory, and routes the response back to that requester.
- On contention it applies round-robin so neither cache starves.

Parameters:
ADDR_W, 16, byte address width of block requests
BLOCK_W, 128, block data width (matches lc3b_block)

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
i_read  in  1  I-cache block read request
i_write  in  1  I-cache block write request (normally 0)
i_addr  in  ADDR_W  I-cache block address
i_wdata  in  BLOCK_W  I-cache write data
i_resp  out  1  I-cache transaction complete
i_rdata  out  BLOCK_W  read data to I-cache
d_read  in  1  D-cache block read request
d_write  in  1  D-cache write-back request
d_addr  in  ADDR_W  D-cache block address
d_wdata  in  BLOCK_W  D-cache write-back data
d_resp  out  1  D-cache transaction complete
d_rdata  out  BLOCK_W  read data to D-cache
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_addr  out  ADDR_W  memory address
pmem_wdata  out  BLOCK_W  memory write data
pmem_rdata  in  BLOCK_W  memory read data
pmem_resp  in  1  memory transaction complete

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- State machine states: IDLE, SERVE_I, SERVE_D. A last_grant register holds I or D.
- Reset values:
  - state = IDLE, last_grant = I (so D wins the first tie).
  - All outputs 0: pmem_read/write, i_resp/d_resp, pmem_addr, pmem_wdata.
- Request definitions: req_i = i_read|i_write; req_d = d_read|d_write.
- IDLE transitions, evaluated at the clock edge:
  - only req_i -> SERVE_I
  - only req_d -> SERVE_D
  - both -> grant the side != last_grant
  - neither -> stay in IDLE
  - last_grant updates to the granted side on entry.
- Outputs by state:
  - IDLE: all pmem commands 0, both resp 0.
  - SERVE_I: pmem_read/write/addr/wdata mirror the i_* inputs combinationally; i_resp = pmem_resp; d_resp = 0.
  - SERVE_D: symmetric, mirroring the d_* inputs.
- i_rdata and d_rdata both carry pmem_rdata unconditionally. Requesters qualify it with their own resp.
- Completion: in SERVE_x with pmem_resp = 1 -> IDLE next cycle.
  - One dead IDLE cycle between transactions. It guarantees the requester has dropped its request before re-arbitration.
- Latency: request asserted in cycle N -> pmem command visible in cycle N+1 -> resp to requester in the same cycle as pmem_resp.
- Requester protocol:
  - Requests are held until resp.
  - Withdrawing a request mid-transaction is illegal; the arbiter still holds the grant until pmem_resp.
  - Asserting read and write together is illegal; both are forwarded unchanged, with no checking.
- Non-granted requester sees resp = 0 and waits; no request is dropped.
- Stray pmem_resp while in IDLE is ignored: no resp is generated and state is unchanged.
- Reset mid-transaction: next cycle state = IDLE, pmem commands = 0, the in-flight memory response is discarded, and last_grant = I.
- Back-to-back from the same requester with no competition is served every 2+ memory cycles. No throttling.

Test Plan:
- I-only read: i_read=1, i_addr=16'h0040; memory resp after 3 cycles with rdata=128'hA5..A5 -> pmem_read=1, pmem_addr=0040 from cycle 1; i_resp=1 for exactly the pmem_resp cycle; d_resp=0 throughout; IDLE the following cycle.
- Simultaneous request after reset: i_read and d_write (d_addr=16'h1230) in the same cycle -> D served first (pmem_write=1, pmem_addr=1230, pmem_wdata=d_wdata); after d_resp, I served with no request lost.
- Round-robin: both requesting continuously for 6 transactions -> grants alternate D,I,D,I,D,I; no consecutive grants to one side while the other waits.
- Hold under contention: D holds d_read while I is served with 5-cycle memory latency -> d_resp stays 0; pmem_addr never shows d_addr until SERVE_D.
- Reset mid-SERVE_D: assert reset 2 cycles into a D read -> next cycle pmem_read=0, state IDLE; a late pmem_resp produces no d_resp; after reset releases with both requesting, D wins.
- Stray response: pulse pmem_resp in IDLE with no requests -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//
// Purpose:
//   Shares one physical-memory port between the LC-3b I-cache and D-cache.
//   Each cache issues whole-block (128-bit) read or write-back requests.
//   One requester is granted at a time. Its command is forwarded to memory
//   combinationally, and the memory response is routed back to it.
//   When both caches request in the same IDLE cycle, the side that was not
//   granted last time wins, so neither cache can starve.
//
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   i_read/i_write        - I-cache block read / write request
//   i_addr/i_wdata        - I-cache block address / write data
//   i_resp/i_rdata        - I-cache completion strobe / read data
//   d_read/d_write        - D-cache block read / write-back request
//   d_addr/d_wdata        - D-cache block address / write-back data
//   d_resp/d_rdata        - D-cache completion strobe / read data
//   pmem_read/pmem_write  - memory command
//   pmem_addr/pmem_wdata  - memory address / write data
//   pmem_rdata/pmem_resp  - memory read data / completion strobe
module cache_mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int BLOCK_W = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_read,
  input  logic               i_write,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BLOCK_W-1:0] i_wdata,
  output logic               i_resp,
  output logic [BLOCK_W-1:0] i_rdata,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [BLOCK_W-1:0] d_wdata,
  output logic               d_resp,
  output logic [BLOCK_W-1:0] d_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [ADDR_W-1:0]  pmem_addr,
  output logic [BLOCK_W-1:0] pmem_wdata,
  input  logic [BLOCK_W-1:0] pmem_rdata,
  input  logic               pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_t r_state;
  state_t w_state_next;
  logic   r_last_grant;
  logic   w_last_grant_next;
  logic   w_req_i;
  logic   w_req_d;

  assign w_req_i = i_read | i_write;
  assign w_req_d = d_read | d_write;

  // Read data goes to both caches unconditionally.
  // Each cache qualifies it with its own resp strobe.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_last_grant <= GRANT_I;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    pmem_read         = 1'b0;
    pmem_write        = 1'b0;
    pmem_addr         = '0;
    pmem_wdata        = '0;
    i_resp            = 1'b0;
    d_resp            = 1'b0;

    case (r_state)
      IDLE: begin
        // pmem_resp is deliberately ignored here.
        // A stray response with no grant outstanding has no owner.
        if (w_req_i && w_req_d) begin
          if (r_last_grant == GRANT_I) begin
            w_state_next      = SERVE_D;
            w_last_grant_next = GRANT_D;
          end else begin
            w_state_next      = SERVE_I;
            w_last_grant_next = GRANT_I;
          end
        end else if (w_req_i) begin
          w_state_next      = SERVE_I;
          w_last_grant_next = GRANT_I;
        end else if (w_req_d) begin
          w_state_next      = SERVE_D;
          w_last_grant_next = GRANT_D;
        end
      end

      SERVE_I: begin
        pmem_read  = i_read;
        pmem_write = i_write;
        pmem_addr  = i_addr;
        pmem_wdata = i_wdata;
        i_resp     = pmem_resp;
        // The grant is held until memory answers, even if the request drops.
        // The IDLE cycle that follows gives the requester time to deassert
        // before the next arbitration.
        if (pmem_resp) begin
          w_state_next = IDLE;
        end
      end

      SERVE_D: begin
        pmem_read  = d_read;
        pmem_write = d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        d_resp     = pmem_resp;
        if (pmem_resp) begin
          w_state_next = IDLE;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

  localparam int AW = 16;
  localparam int BW = 128;

  localparam int O_NONE = 0;
  localparam int O_I    = 1;
  localparam int O_D    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr;
  logic [BW-1:0] i_wdata, d_wdata;
  logic          i_resp, d_resp;
  logic [BW-1:0] i_rdata, d_rdata;
  logic          pmem_read, pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [BW-1:0] pmem_wdata;
  logic [BW-1:0] pmem_rdata;
  logic          pmem_resp;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_read    (i_read),
    .i_write   (i_write),
    .i_addr    (i_addr),
    .i_wdata   (i_wdata),
    .i_resp    (i_resp),
    .i_rdata   (i_rdata),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_resp    (d_resp),
    .d_rdata   (d_rdata),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .pmem_addr (pmem_addr),
    .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata),
    .pmem_resp (pmem_resp)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: who currently owns the memory port, and which side was
  // granted last.
  int   m_owner  = O_NONE;
  logic m_last_d = 1'b0;
  bit   m_valid  = 1'b0;

  // Order in which the DUT granted requests, inferred from memory commands
  logic prev_cmd = 1'b0;
  int   dut_grants[$];
  bit   seen_iresp = 1'b0;
  bit   seen_dresp = 1'b0;

  // Random-phase requester agents and memory model
  bit act_i = 0, act_d = 0;
  int iss_i = 0, done_i = 0, iss_d = 0, done_d = 0;
  int wait_i = 0, wait_d = 0, max_wait = 0;
  int mem_cnt = 0, mem_lat = 2;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle.
  // Inputs are already set by the caller.
  // Outputs are checked against the model mid-cycle, then the model advances
  // at the clock edge.
  task automatic cycle();
    logic          er, ew, eir, edr, ri, rd, nlast;
    logic [AW-1:0] ea;
    logic [BW-1:0] ewd;
    int            nxt;
    bit            nvalid;
    #1;
    if (m_valid) begin
      er = 1'b0; ew = 1'b0; eir = 1'b0; edr = 1'b0; ea = '0; ewd = '0;
      if (m_owner == O_I) begin
        er = i_read; ew = i_write; ea = i_addr; ewd = i_wdata; eir = pmem_resp;
      end else if (m_owner == O_D) begin
        er = d_read; ew = d_write; ea = d_addr; ewd = d_wdata; edr = pmem_resp;
      end
      chk("pmem_read",  pmem_read,  er);
      chk("pmem_write", pmem_write, ew);
      chk("pmem_addr",  pmem_addr,  ea);
      chk("pmem_wdata", pmem_wdata, ewd);
      chk("i_resp",     i_resp,     eir);
      chk("d_resp",     d_resp,     edr);
      chk("i_rdata",    i_rdata,    pmem_rdata);
      chk("d_rdata",    d_rdata,    pmem_rdata);
    end
    if ((pmem_read | pmem_write) && !prev_cmd)
      dut_grants.push_back((pmem_addr == d_addr && pmem_addr != i_addr) ? O_D : O_I);
    prev_cmd   = pmem_read | pmem_write;
    seen_iresp = (i_resp === 1'b1);
    seen_dresp = (d_resp === 1'b1);

    ri = i_read | i_write;
    rd = d_read | d_write;
    nxt    = m_owner;
    nlast  = m_last_d;
    nvalid = m_valid | reset;
    if (reset) begin
      nxt   = O_NONE;
      nlast = 1'b0;
    end else if (m_owner != O_NONE) begin
      if (pmem_resp) nxt = O_NONE;
    end else begin
      if (ri && rd)  nxt = m_last_d ? O_I : O_D;
      else if (ri)   nxt = O_I;
      else if (rd)   nxt = O_D;
      if (nxt != O_NONE) nlast = (nxt == O_D);
    end
    @(posedge clk);
    m_owner  = nxt;
    m_last_d = nlast;
    m_valid  = nvalid;
    #1;
  endtask

  task automatic mem_txn(input int lat, input logic [BW-1:0] rdat);
    for (int k = 1; k < lat; k++) begin
      pmem_resp = 1'b0;
      cycle();
    end
    pmem_rdata = rdat;
    pmem_resp  = 1'b1;
    cycle();
    pmem_resp = 1'b0;
  endtask

  task automatic rand_step(input bit gen);
    bit w;
    if (act_i && seen_iresp) begin
      act_i = 0; i_read = 0; i_write = 0; done_i++;
    end else if (!act_i && gen && ($urandom % 2 == 0)) begin
      act_i = 1; iss_i++; wait_i = 0;
      w = ($urandom % 8 == 0);
      i_read = !w; i_write = w;
      i_addr = AW'($urandom); i_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    if (act_d && seen_dresp) begin
      act_d = 0; d_read = 0; d_write = 0; done_d++;
    end else if (!act_d && gen && ($urandom % 2 == 0)) begin
      act_d = 1; iss_d++; wait_d = 0;
      w = ($urandom % 2 == 0);
      d_read = !w; d_write = w;
      d_addr = AW'($urandom); d_wdata = {$urandom, $urandom, $urandom, $urandom};
    end
    if (act_i) begin wait_i++; if (wait_i > max_wait) max_wait = wait_i; end
    if (act_d) begin wait_d++; if (wait_d > max_wait) max_wait = wait_d; end
    if (pmem_read | pmem_write) begin
      mem_cnt++;
      if (mem_cnt >= mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        mem_cnt    = 0;
        mem_lat    = $urandom_range(1, 4);
      end else begin
        pmem_resp = 1'b0;
      end
    end else begin
      mem_cnt   = 0;
      pmem_resp = ($urandom % 8 == 0);
    end
    cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_pmem_read", pmem_read, 0);
    chk("reset_resp", {i_resp, d_resp}, 0);

    // Stray memory response while idle
    pmem_resp = 1'b1;
    pmem_rdata = {4{32'h5A5A_1234}};
    cycle();
    pmem_resp = 1'b0;
    chk("stray_stay_idle", pmem_read | pmem_write, 0);
    cycle();

    // I-only read
    i_read = 1; i_addr = 16'h0040; i_wdata = '0;
    cycle();
    chk("t1_cmd_read", pmem_read, 1);
    chk("t1_cmd_addr", pmem_addr, 16'h0040);
    mem_txn(3, {16{8'hA5}});
    i_read = 0;
    chk("t1_idle_after", pmem_read, 0);
    cycle();

    // Simultaneous request after reset: D wins
    reset = 1; cycle(); reset = 0;
    i_read = 1; i_addr = 16'h0100;
    d_write = 1; d_addr = 16'h1230; d_wdata = {4{32'hDEAD_BEEF}};
    cycle();
    chk("t2_d_first_write", pmem_write, 1);
    chk("t2_d_first_addr", pmem_addr, 16'h1230);
    chk("t2_d_first_wdata", pmem_wdata, {4{32'hDEAD_BEEF}});
    mem_txn(2, '0);
    d_write = 0;
    cycle();
    chk("t2_i_second", pmem_addr, 16'h0100);
    mem_txn(2, {4{32'h1111_2222}});
    i_read = 0;
    cycle();

    // Round-robin with both sides requesting continuously
    dut_grants.delete();
    i_read = 1; i_addr = 16'h0100;
    d_read = 1; d_addr = 16'h0200;
    cycle();
    for (int t = 0; t < 6; t++) begin
      mem_txn(1 + t % 3, {4{$urandom}});
      if (t == 5) begin i_read = 0; d_read = 0; end
      cycle();
    end
    chk("rr_count", dut_grants.size(), 6);
    for (int k = 0; k < 6; k++)
      chk("rr_grant", (dut_grants.size() > k) ? dut_grants[k] : -1,
          (k % 2 == 0) ? O_D : O_I);

    // D holds its request while I is served with 5-cycle memory latency
    i_read = 1; i_addr = 16'h0440;
    cycle();
    d_read = 1; d_addr = 16'h0880;
    mem_txn(5, {4{32'hCAFE_0001}});
    i_read = 0;
    cycle();
    chk("hold_d_served", pmem_addr, 16'h0880);
    mem_txn(2, {4{32'hCAFE_0002}});
    d_read = 0;
    cycle();

    // Reset two cycles into a D read
    d_read = 1; d_addr = 16'h0300;
    cycle();
    cycle();
    cycle();
    reset = 1; i_read = 1; i_addr = 16'h0500;
    cycle();
    reset = 0;
    chk("rst_cmd_off", pmem_read, 0);
    pmem_resp = 1'b1;
    cycle();
    pmem_resp = 1'b0;
    chk("rst_d_wins", pmem_addr, 16'h0300);
    mem_txn(1, {4{32'h0BAD_F00D}});
    d_read = 0;
    cycle();
    mem_txn(1, {4{32'h600D_F00D}});
    i_read = 0;
    cycle();

    // Randomized traffic against the model
    seen_iresp = 0; seen_dresp = 0;
    for (int n = 0; n < 800; n++) rand_step(1'b1);
    for (int n = 0; n < 100 && (act_i || act_d); n++) rand_step(1'b0);
    chk("drain_idle", act_i | act_d, 0);
    chk("no_lost_i", done_i, iss_i);
    chk("no_lost_d", done_d, iss_d);
    chk("activity", (iss_i > 20 && iss_d > 20), 1);
    chk("max_wait_bounded", (max_wait <= 16), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
